timer_bank: RTL and testbench

- Memory-mapped bank of NUM_TIMERS independent up-counting timers on the CPU data bus, next to the existing LED/digit/systick registers.
- Each channel has:
  - a reload value
  - a live counter
  - a programmable prescaler
  - auto-reload or one-shot mode
  - a sticky pending flag
- Adds a free-running systick and an aggregated interrupt line, gated by the CPU's kernel-mode `check` input.

---
 rtl/timer_bank.sv | 168 ++++++++++++++++
 tb/tb_timer_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// Memory-mapped bank of prescaled up-counting timers with a free-running
// systick and one aggregated interrupt line masked in kernel mode.
module timer_bank #(
  parameter int          NUM_TIMERS  = 4,
  parameter int          CNT_WIDTH   = 32,
  parameter int          PRESC_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        check,
  output logic [31:0] rdata,
  output logic        interrupt
);

  localparam int CW = CNT_WIDTH;
  localparam int PW = PRESC_WIDTH;

  logic [7:0] off;
  logic [2:0] ch_idx;
  logic       blk_hit;
  logic       chan_hit;
  logic       irq_hit;
  logic       tick_hit;
  logic       wr_irq;

  assign off      = addr[7:0];
  assign ch_idx   = off[6:4];
  assign blk_hit  = (addr[31:8] == BASE_ADDR[31:8]) &&
                    (addr[1:0] == 2'b00);
  assign chan_hit = blk_hit && !off[7] &&
                    (32'(ch_idx) < NUM_TIMERS);
  assign irq_hit  = blk_hit && (off == 8'h80);
  assign tick_hit = blk_hit && (off == 8'h84);
  assign wr_irq   = Write && irq_hit;

  logic [NUM_TIMERS-1:0]       pend;
  logic [NUM_TIMERS-1:0]       ie;
  logic [NUM_TIMERS-1:0][31:0] ch_rd;

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    logic          sel;
    logic          wr_rel;
    logic          wr_cnt;
    logic          wr_ctl;
    logic          wr_sts;
    logic [CW-1:0] reload_q;
    logic [CW-1:0] count_q;
    logic          en_q;
    logic          ie_q;
    logic          os_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] pc_q;
    logic          pend_q;
    logic          tick;
    logic          ovf;
    logic          clr;
    logic [31:0]   rd;

    assign sel    = chan_hit && (ch_idx == 3'(g));
    assign wr_rel = Write && sel && (off[3:2] == 2'd0);
    assign wr_cnt = Write && sel && (off[3:2] == 2'd1);
    assign wr_ctl = Write && sel && (off[3:2] == 2'd2);
    assign wr_sts = Write && sel && (off[3:2] == 2'd3);

    assign tick = en_q && (pc_q == presc_q);
    assign ovf  = tick && (&count_q);
    assign clr  = (wr_sts && wdata[0]) ||
                  (wr_irq && wdata[g]);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        reload_q <= '0;
        count_q  <= '0;
        en_q     <= 1'b0;
        ie_q     <= 1'b0;
        os_q     <= 1'b0;
        presc_q  <= '0;
        pc_q     <= '0;
        pend_q   <= 1'b0;
      end else begin
        if (wr_rel)
          reload_q <= wdata[CW-1:0];

        // Bus writes take priority over the counter's own update
        if (wr_cnt)
          count_q <= wdata[CW-1:0];
        else if (ovf)
          count_q <= reload_q;
        else if (tick)
          count_q <= count_q + CW'(1);

        if (wr_ctl) begin
          en_q    <= wdata[0];
          ie_q    <= wdata[1];
          os_q    <= wdata[2];
          presc_q <= wdata[8 +: PW];
        end else if (ovf && os_q) begin
          en_q <= 1'b0;
        end

        if (wr_ctl || !en_q || tick)
          pc_q <= '0;
        else
          pc_q <= pc_q + PW'(1);

        // A new overflow beats a simultaneous clear
        if (ovf)
          pend_q <= 1'b1;
        else if (clr)
          pend_q <= 1'b0;
      end
    end

    always_comb begin
      rd = '0;
      case (off[3:2])
        2'd0: rd = 32'(reload_q);
        2'd1: rd = 32'(count_q);
        2'd2: begin
          rd[0]      = en_q;
          rd[1]      = ie_q;
          rd[2]      = os_q;
          rd[8 +: PW] = presc_q;
        end
        default: rd[0] = pend_q;
      endcase
    end

    assign ch_rd[g] = rd;
    assign pend[g]  = pend_q;
    assign ie[g]    = ie_q;
  end

  logic [31:0] systick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      systick_q <= '0;
    else if (Write && tick_hit)
      systick_q <= wdata;
    else
      systick_q <= systick_q + 32'd1;
  end

  always_comb begin
    rdata = '0;
    if (Read) begin
      unique case (1'b1)
        chan_hit: begin
          for (int i = 0; i < NUM_TIMERS; i++)
            if (ch_idx == 3'(i))
              rdata = ch_rd[i];
        end
        irq_hit:  rdata = 32'(pend);
        tick_hit: rdata = systick_q;
        default:  rdata = '0;
      endcase
    end
  end

  assign interrupt = !check && (|(pend & ie));

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register table plus
// multi-cycle sequences for counting, collisions and reset.
module tb_timer_bank;

  localparam logic [31:0] B = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        check = 1'b0;
  logic [31:0] rdata;
  logic        interrupt;

  int total = 0;
  int bad = 0;

  timer_bank #(
    .NUM_TIMERS(4),
    .CNT_WIDTH(32),
    .PRESC_WIDTH(8),
    .BASE_ADDR(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Read(Read),
    .Write(Write),
    .addr(addr),
    .wdata(wdata),
    .check(check),
    .rdata(rdata),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rd;
    logic [31:0] ra;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Write = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    Write = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chkrd(input string nm, input logic [31:0] a,
                       input logic [31:0] exp);
    Read = 1'b1;
    addr = a;
    #1;
    chk(nm, rdata, exp);
    Read = 1'b0;
  endtask

  task automatic chkirq(input string nm, input logic e);
    chk(nm, {31'b0, interrupt}, {31'b0, e});
  endtask

  initial begin
    vt.push_back(vec_t'{1'b1, B+32'h30, 32'h1234_5678, 1'b1, B+32'h30, 32'h1234_5678, "reload_rw"});
    vt.push_back(vec_t'{1'b1, B+32'h34, 32'hCAFE_0000, 1'b1, B+32'h34, 32'hCAFE_0000, "count_rw"});
    vt.push_back(vec_t'{1'b1, B+32'h38, 32'hFFFF_FFFA, 1'b1, B+32'h38, 32'h0000_FF02, "ctrl_mask"});
    vt.push_back(vec_t'{1'b1, B+32'h42, 32'hFFFF_FFFF, 1'b1, B+32'h42, 32'h0, "unaligned"});
    vt.push_back(vec_t'{1'b1, B+32'h40, 32'h0000_FFFF, 1'b1, B+32'h40, 32'h0, "chan_oob"});
    vt.push_back(vec_t'{1'b1, B+32'h88, 32'h0000_FFFF, 1'b1, B+32'h88, 32'h0, "off_88"});
    vt.push_back(vec_t'{1'b1, B+32'h31, 32'h0000_0000, 1'b1, B+32'h30, 32'h1234_5678, "reload_kept"});
    vt.push_back(vec_t'{1'b0, 32'h0, 32'h0, 1'b0, B+32'h34, 32'h0, "read_gated"});
    vt.push_back(vec_t'{1'b0, 32'h0, 32'h0, 1'b1, B+32'h34, 32'hCAFE_0000, "count_kept"});
    vt.push_back(vec_t'{1'b1, B+32'h3C, 32'h1, 1'b1, B+32'h3C, 32'h0, "status_idle"});
    vt.push_back(vec_t'{1'b0, 32'h0, 32'h0, 1'b1, B+32'h100, 32'h0, "outside_blk"});
    vt.push_back(vec_t'{1'b0, 32'h0, 32'h0, 1'b1, B+32'h00, 32'h0, "ch0_no_alias"});
    vt.push_back(vec_t'{1'b0, 32'h0, 32'h0, 1'b1, B+32'h80, 32'h0, "irqpend_zero"});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chkirq("rst_irq", 1'b0);
    chkrd("rst_systick", B+32'h84, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    chkrd("rst_count0", B+32'h04, 32'h0);
    chkrd("rst_ctrl0", B+32'h08, 32'h0);

    foreach (vt[i]) begin
      if (vt[i].do_wr)
        wr(vt[i].wa, vt[i].wd);
      Read = vt[i].rd;
      addr = vt[i].ra;
      #1;
      chk(vt[i].nm, rdata, vt[i].exp);
      Read = 1'b0;
    end

    // auto-reload on channel 0
    wr(B+32'h00, 32'hFFFF_FFFD);
    wr(B+32'h04, 32'hFFFF_FFFD);
    wr(B+32'h08, 32'h3);
    chkrd("ar_c0", B+32'h04, 32'hFFFF_FFFD);
    cyc(1);
    chkrd("ar_c1", B+32'h04, 32'hFFFF_FFFE);
    cyc(1);
    chkrd("ar_c2", B+32'h04, 32'hFFFF_FFFF);
    chkrd("ar_nopend", B+32'h0C, 32'h0);
    cyc(1);
    chkrd("ar_reload", B+32'h04, 32'hFFFF_FFFD);
    chkrd("ar_pend", B+32'h0C, 32'h1);
    chkirq("ar_irq", 1'b1);
    wr(B+32'h0C, 32'h1);
    chkirq("w1c_irq", 1'b0);
    chkrd("w1c_status", B+32'h0C, 32'h0);
    chkrd("w1c_count", B+32'h04, 32'hFFFF_FFFE);
    cyc(1);
    wr(B+32'h0C, 32'h1);
    chkrd("coll_pend", B+32'h0C, 32'h1);
    chkrd("coll_count", B+32'h04, 32'hFFFF_FFFD);
    wr(B+32'h08, 32'h0);
    wr(B+32'h80, 32'h1);
    chkrd("irqpend_clr", B+32'h80, 32'h0);
    chkrd("stop_count", B+32'h04, 32'hFFFF_FFFE);
    cyc(3);
    chkrd("stop_hold", B+32'h04, 32'hFFFF_FFFE);

    // prescaler on channel 1
    wr(B+32'h14, 32'h0);
    wr(B+32'h18, 32'h301);
    cyc(4);
    chkrd("presc_4", B+32'h14, 32'h1);
    cyc(16);
    chkrd("presc_20", B+32'h14, 32'h5);
    chkrd("presc_ch0", B+32'h04, 32'hFFFF_FFFE);
    cyc(3);
    wr(B+32'h14, 32'h5);
    chkrd("cnt_wr_wins", B+32'h14, 32'h5);
    cyc(4);
    chkrd("presc_next", B+32'h14, 32'h6);
    wr(B+32'h18, 32'h0);

    // one-shot on channel 2
    wr(B+32'h20, 32'h10);
    wr(B+32'h24, 32'hFFFF_FFFE);
    wr(B+32'h28, 32'h7);
    chkrd("os_c0", B+32'h24, 32'hFFFF_FFFE);
    cyc(1);
    chkrd("os_c1", B+32'h24, 32'hFFFF_FFFF);
    chkrd("os_nopend", B+32'h2C, 32'h0);
    cyc(1);
    chkrd("os_reload", B+32'h24, 32'h10);
    chkrd("os_en_off", B+32'h28, 32'h6);
    chkrd("os_pend", B+32'h2C, 32'h1);
    chkirq("os_irq", 1'b1);
    check = 1'b1;
    #1;
    chkirq("mask_on", 1'b0);
    check = 1'b0;
    #1;
    chkirq("mask_off", 1'b1);
    cyc(50);
    chkrd("os_hold", B+32'h24, 32'h10);
    chkrd("irqpend_ch2", B+32'h80, 32'h4);
    wr(B+32'h80, 32'hF);
    chkrd("irqpend_all", B+32'h80, 32'h0);
    chkirq("irq_cleared", 1'b0);

    // CTRL write on the one-shot overflow cycle
    wr(B+32'h24, 32'hFFFF_FFFE);
    wr(B+32'h28, 32'h7);
    cyc(1);
    wr(B+32'h28, 32'h7);
    chkrd("ctl_wins", B+32'h28, 32'h7);
    chkrd("ctl_wins_cnt", B+32'h24, 32'h10);
    chkrd("ctl_wins_pend", B+32'h2C, 32'h1);
    cyc(1);
    chkrd("ctl_wins_run", B+32'h24, 32'h11);
    wr(B+32'h28, 32'h0);
    wr(B+32'h80, 32'hF);

    // systick load
    wr(B+32'h84, 32'd100);
    chkrd("systick_ld", B+32'h84, 32'd100);
    cyc(1);
    chkrd("systick_inc", B+32'h84, 32'd101);

    // async reset mid-count
    wr(B+32'h00, 32'h0);
    wr(B+32'h04, 32'hFFFF_FFFE);
    wr(B+32'h08, 32'h3);
    cyc(3);
    chkirq("pre_rst_irq", 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chkirq("arst_irq", 1'b0);
    chkrd("arst_count", B+32'h04, 32'h0);
    chkrd("arst_ctrl", B+32'h08, 32'h0);
    chkrd("arst_status", B+32'h0C, 32'h0);
    chkrd("arst_irqpend", B+32'h80, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(3);
    chkrd("arst_idle", B+32'h04, 32'h0);
    wr(B+32'h08, 32'h1);
    cyc(2);
    chkrd("arst_resume", B+32'h04, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
